// File: rtl/finger_key_scanner.sv
// Per-frame finger key detector: counts finger pixels per key column inside a row band
// and turns the counts into debounced key states with press/release event masks.
module finger_key_scanner #(
  parameter int unsigned NUM_KEYS   = 40,
  parameter int unsigned KEY_SHIFT  = 4,
  parameter int unsigned FRAME_W    = 640,
  parameter int unsigned ROI_Y0     = 321,
  parameter int unsigned ROI_Y1     = 479,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ON_THRESH  = 16,
  parameter int unsigned OFF_THRESH = 8,
  parameter int unsigned DEBOUNCE   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic                pix_finger,
  input  logic                frame_done,
  input  logic                mirror,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                result_valid,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned POS_W = 16;
  localparam int unsigned STK_W = 4;
  localparam logic [POS_W-1:0] XLast  = POS_W'(FRAME_W - 1);
  localparam logic [POS_W-1:0] KeyLim = POS_W'(NUM_KEYS);
  localparam logic [POS_W-1:0] BandY0 = POS_W'(ROI_Y0);
  localparam logic [POS_W-1:0] BandY1 = POS_W'(ROI_Y1);
  localparam logic [STK_W-1:0] DebN   = STK_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic                init_q;
  logic                mirror_q, mirror_d;
  logic [POS_W-1:0]    x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [STK_W-1:0]    stk_q [NUM_KEYS];
  logic [STK_W-1:0]    stk_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] down_q, down_d, press_q, press_d, rel_q, rel_d;
  logic                valid_q, valid_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic                mir_eff;
  logic [POS_W-1:0]    x_eff, key_idx;
  logic                in_band, hit, row_end, cand;

  // First cycle after reset release picks up the live mirror input for the opening frame.
  always_comb begin
    mir_eff  = init_q ? mirror : mirror_q;
    x_eff    = init_q ? (mirror ? XLast : '0) : x_q;
    key_idx  = x_eff >> KEY_SHIFT;
    in_band  = (y_q >= BandY0) && (y_q <= BandY1);
    hit      = pix_valid && pix_finger && in_band && (key_idx < KeyLim);
    row_end  = mir_eff ? (x_eff == '0) : (x_eff == XLast);
    cand     = 1'b0;

    mirror_d = mir_eff;
    x_d      = x_eff;
    y_d      = y_q;
    cnt_d    = cnt_q;
    stk_d    = stk_q;
    down_d   = down_q;
    press_d  = '0;
    rel_d    = '0;
    valid_d  = 1'b0;
    fcnt_d   = fcnt_q;

    if (frame_done) begin
      // Frame boundary wins over any coincident pixel.
      mirror_d = mirror;
      x_d      = mirror ? XLast : '0;
      y_d      = '0;
      fcnt_d   = fcnt_q + 16'd1;
      valid_d  = 1'b1;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        cand     = down_q[k] ? (32'(cnt_q[k]) >= OFF_THRESH) : (32'(cnt_q[k]) >= ON_THRESH);
        cnt_d[k] = '0;
        if (cand == down_q[k]) begin
          stk_d[k] = '0;
        end else if (stk_q[k] + STK_W'(1) == DebN) begin
          down_d[k] = ~down_q[k];
          stk_d[k]  = '0;
        end else begin
          stk_d[k] = stk_q[k] + STK_W'(1);
        end
      end
      press_d = down_d & ~down_q;
      rel_d   = ~down_d & down_q;
    end else if (pix_valid) begin
      if (row_end) begin
        x_d = mir_eff ? XLast : '0;
        y_d = (y_q == '1) ? y_q : y_q + POS_W'(1);
      end else begin
        x_d = mir_eff ? x_eff - POS_W'(1) : x_eff + POS_W'(1);
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (hit && (key_idx == POS_W'(k)) && (cnt_q[k] != CntMax)) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q   <= 1'b1;
      mirror_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
        stk_q[k] <= '0;
      end
      down_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      valid_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      init_q   <= 1'b0;
      mirror_q <= mirror_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      stk_q    <= stk_d;
      down_q   <= down_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      valid_q  <= valid_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign key_down     = down_q;
  assign key_press    = press_q;
  assign key_release  = rel_q;
  assign result_valid = valid_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_finger_key_scanner.sv
// Directed bench for finger_key_scanner: 4 keys of 4 px, 16 px rows, band rows 2-3,
// plus a narrow-counter instance (band rows 2-6) for saturation.
module tb_finger_key_scanner;

  logic        clk = 1'b0;
  logic        rst, pix_valid, pix_finger, frame_done, mirror;
  logic [3:0]  key_down, key_press, key_release;
  logic        result_valid;
  logic [15:0] frame_cnt;
  logic [3:0]  s_down, s_press, s_release;
  logic        s_valid;
  logic [15:0] s_fcnt;

  int n_chk  = 0;
  int n_fail = 0;

  finger_key_scanner #(
    .NUM_KEYS(4), .KEY_SHIFT(2), .FRAME_W(16), .ROI_Y0(2), .ROI_Y1(3),
    .CNT_W(16), .ON_THRESH(4), .OFF_THRESH(2), .DEBOUNCE(2)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_finger(pix_finger),
    .frame_done(frame_done), .mirror(mirror), .key_down(key_down),
    .key_press(key_press), .key_release(key_release),
    .result_valid(result_valid), .frame_cnt(frame_cnt)
  );

  finger_key_scanner #(
    .NUM_KEYS(4), .KEY_SHIFT(2), .FRAME_W(16), .ROI_Y0(2), .ROI_Y1(6),
    .CNT_W(3), .ON_THRESH(4), .OFF_THRESH(2), .DEBOUNCE(2)
  ) u_sat (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_finger(pix_finger),
    .frame_done(frame_done), .mirror(mirror), .key_down(s_down),
    .key_press(s_press), .key_release(s_release),
    .result_valid(s_valid), .frame_cnt(s_fcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r0, r1, r2, r3, r4;
    logic [3:0]  down, press, rel;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic pix(input logic v, input logic f);
    pix_valid  = v;
    pix_finger = f;
    @(negedge clk);
  endtask

  task automatic send_row(input logic [15:0] bits);
    for (int i = 0; i < 16; i++) pix(1'b1, bits[i]);
  endtask

  task automatic send_frame(input logic [15:0] r0, r1, r2, r3, r4);
    send_row(r0); send_row(r1); send_row(r2); send_row(r3); send_row(r4);
  endtask

  task automatic fd();
    pix_valid  = 1'b0;
    pix_finger = 1'b0;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [3:0] d, p, r, input logic [15:0] fc);
    check({tag, "_valid"},   32'(result_valid), 32'd1);
    check({tag, "_down"},    32'(key_down), 32'(d));
    check({tag, "_press"},   32'(key_press), 32'(p));
    check({tag, "_release"}, 32'(key_release), 32'(r));
    check({tag, "_fcnt"},    32'(frame_cnt), 32'(fc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h0000, 16'h0000, 16'h00F0, 16'h00F0, 16'h0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{16'h0000, 16'h0000, 16'h00F0, 16'h00F0, 16'h0000, 4'b0010, 4'b0010, 4'b0000};
    tbl[2]  = '{16'h0000, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[3]  = '{16'h0000, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[4]  = '{16'h0000, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[5]  = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[6]  = '{16'h0000, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[7]  = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 4'b0000};
    tbl[8]  = '{16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0010};
    tbl[9]  = '{16'h0000, 16'h0000, 16'hF00F, 16'hF000, 16'h0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{16'h0000, 16'h0000, 16'hF00F, 16'hF000, 16'h0000, 4'b1001, 4'b1001, 4'b0000};
    tbl[11] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1001, 4'b0000, 4'b0000};
    tbl[12] = '{16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 4'b1000};
    tbl[13] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[14] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0001};
    tbl[15] = '{16'h0000, 16'h0000, 16'h0700, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{16'h0000, 16'h0000, 16'h0700, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b0; pix_valid = 1'b0; pix_finger = 1'b0; frame_done = 1'b0; mirror = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_down", 32'(key_down), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    pix(1'b0, 1'b0);

    // Press debounce, hysteresis, threshold edges, band rejection.
    for (int i = 0; i < 20; i++) begin
      send_frame(tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].r4);
      fd();
      check_res($sformatf("vec%0d", i), tbl[i].down, tbl[i].press, tbl[i].rel, 16'(i + 1));
      pix(1'b0, 1'b0);
      check($sformatf("vec%0d_pulse", i), {29'd0, result_valid, |key_press, |key_release}, 32'd0);
    end

    // Back-to-back frame_done: two evaluations, two result pulses.
    send_frame(16'h0, 16'h0, 16'h00F0, 16'h00F0, 16'h0);
    fd();
    check_res("b2b_pre", 4'b0000, 4'b0000, 4'b0000, 16'd21);
    send_frame(16'h0, 16'h0, 16'h00F0, 16'h00F0, 16'h0);
    pix_valid = 1'b0; frame_done = 1'b1;
    @(negedge clk);
    check_res("b2b_first", 4'b0010, 4'b0010, 4'b0000, 16'd22);
    @(negedge clk);
    frame_done = 1'b0;
    check_res("b2b_second", 4'b0010, 4'b0000, 4'b0000, 16'd23);
    send_frame(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    fd();
    check_res("b2b_release", 4'b0000, 4'b0000, 4'b0010, 16'd24);

    // Finger pixel at x=3 coincident with frame_done must vanish from both frames.
    send_row(16'h0); send_row(16'h0);
    pix(1'b1, 1'b1); pix(1'b1, 1'b1); pix(1'b1, 1'b1);
    pix_valid = 1'b1; pix_finger = 1'b1; frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    check_res("coll_a", 4'b0000, 4'b0000, 4'b0000, 16'd25);
    send_frame(16'h0, 16'h0, 16'h000F, 16'h0, 16'h0);
    fd();
    check_res("coll_b", 4'b0000, 4'b0000, 4'b0000, 16'd26);
    send_frame(16'h0, 16'h0, 16'h000F, 16'h0, 16'h0);
    fd();
    check_res("coll_c", 4'b0001, 4'b0001, 4'b0000, 16'd27);

    // Mirror takes effect only from the frame after it is latched.
    mirror = 1'b1;
    fd();
    mirror = 1'b0;
    check_res("mir_latch", 4'b0001, 4'b0000, 4'b0000, 16'd28);
    send_frame(16'h0, 16'h0, 16'h000F, 16'h000F, 16'h0);
    mirror = 1'b1;
    fd();
    check_res("mir_f1", 4'b0000, 4'b0000, 4'b0001, 16'd29);
    send_frame(16'h0, 16'h0, 16'h000F, 16'h000F, 16'h0);
    mirror = 1'b0;
    fd();
    check_res("mir_f2", 4'b1000, 4'b1000, 4'b0000, 16'd30);

    // Reset in the middle of a frame after 20 finger pixels in the band.
    send_row(16'h0); send_row(16'h0);
    send_row(16'hFFFF);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1);
    pix_valid = 1'b0; pix_finger = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_down", 32'(key_down), 32'd0);
    check("midrst_press", 32'(key_press), 32'd0);
    check("midrst_release", 32'(key_release), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b1;
    send_frame(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    fd();
    check_res("post_rst_x", 4'b0000, 4'b0000, 4'b0000, 16'd1);
    send_frame(16'h0, 16'h0, 16'h000F, 16'h0, 16'h0);
    fd();
    check_res("post_rst_y", 4'b0000, 4'b0000, 4'b0000, 16'd2);

    // Saturation: 20 finger pixels on key 2 into a 3-bit counter.
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 7; r++) send_row((r >= 2) ? 16'h0F00 : 16'h0000);
      check($sformatf("sat%0d_cnt", f), 32'(u_sat.cnt_q[2]), 32'd7);
      fd();
      check($sformatf("sat%0d_down", f), 32'(s_down), (f == 1) ? 32'h4 : 32'h0);
      check($sformatf("sat%0d_press", f), 32'(s_press), (f == 1) ? 32'h4 : 32'h0);
      check($sformatf("sat%0d_main_down", f), 32'(key_down), (f == 1) ? 32'h4 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
